// File: rtl/instr_fetch.sv
// instr_fetch: fetches the word at PC over a req/ack memory handshake and predecodes Jump/imm
module instr_fetch #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        fetch_en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        pc_advance,
    output logic        Jump,
    output logic [31:0] imm,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t             state_q;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        instr_q;
    logic               instr_valid_q;
    logic               pc_advance_q;
    logic               jump_q;
    logic [31:0]        imm_q;
    logic               fetch_err_q;
    logic [CNT_W-1:0]   cnt_q;

    // Fetch FSM; the DONE pulses are one cycle because they default low every cycle
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_advance_q  <= 1'b0;
            jump_q        <= 1'b0;
            imm_q         <= '0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            pc_advance_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        if (PC[1:0] == 2'b00) begin
                            mem_addr_q <= {PC[31:2], 2'b00};
                            mem_req_q  <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= REQ;
                        end else begin
                            fetch_err_q <= 1'b1;
                            state_q     <= ERR;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        instr_q       <= mem_rdata;
                        jump_q        <= mem_rdata[31:26] == 6'b000010;
                        imm_q         <= {{16{mem_rdata[15]}}, mem_rdata[15:0]};
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        pc_advance_q  <= 1'b1;
                        state_q       <= DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                ERR: begin
                    mem_req_q   <= 1'b0;
                    fetch_err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign Instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_advance  = pc_advance_q;
    assign Jump        = jump_q;
    assign imm         = imm_q;
    assign fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: transaction-level checks of instr_fetch against a behavioural fetch model
module tb_instr_fetch;
    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC = '0;
    logic        fetch_en = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        pc_advance;
    logic        Jump;
    logic [31:0] imm;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_instr = '0;

    instr_fetch #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .CLK(CLK), .reset(reset), .PC(PC), .fetch_en(fetch_en),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Instr(Instr), .instr_valid(instr_valid), .pc_advance(pc_advance),
        .Jump(Jump), .imm(imm), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        return w[15] ? (32'hFFFF0000 | (w & 32'h0000FFFF)) : (w & 32'h0000FFFF);
    endfunction

    function automatic logic [31:0] exp_jump(input logic [31:0] w);
        return ((w >> 26) == 32'd2) ? 32'd1 : 32'd0;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        fetch_en = 1'b0;
        mem_ack = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        last_instr = '0;
    endtask

    // One complete fetch starting from IDLE at a negedge; ends at the negedge of the following IDLE cycle
    task automatic fetch(input logic [31:0] pc, input int waits, input logic [31:0] rd,
                         input bit keep_en, output logic [31:0] first_addr, output int adv_n);
        int req_n = 0;
        adv_n = 0;
        PC = pc;
        fetch_en = 1'b1;
        mem_ack = 1'b0;
        chk("idle_req", 32'(mem_req), 32'd0);
        @(negedge CLK);
        if (!keep_en) fetch_en = 1'b0;
        first_addr = mem_addr;
        for (int k = 0; k <= waits; k++) begin
            if (mem_req) req_n++;
            chk("req_addr", mem_addr, pc & 32'hFFFFFFFC);
            chk("req_no_pulse", 32'(instr_valid | pc_advance), 32'd0);
            PC = $urandom;
            mem_ack = (k == waits);
            mem_rdata = (k == waits) ? rd : $urandom;
            @(negedge CLK);
        end
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) req_n++;
        if (pc_advance) adv_n++;
        PC = pc + 32'd4;
        last_instr = rd;
        chk("req_cycles", 32'(req_n), 32'(waits + 1));
        chk("done_valid", 32'(instr_valid), 32'd1);
        chk("done_adv", 32'(pc_advance), 32'd1);
        chk("done_instr", Instr, rd);
        chk("done_jump", 32'(Jump), exp_jump(rd));
        chk("done_imm", imm, exp_imm(rd));
        chk("done_err", 32'(fetch_err), 32'd0);
        @(negedge CLK);
        if (pc_advance) adv_n++;
        chk("after_pulse", 32'(instr_valid | pc_advance | mem_req), 32'd0);
        chk("hold_instr", Instr, rd);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] pc_m;
        logic [31:0] rd;
        int adv;
        int adv_total;
        logic [31:0] addrs[$];

        do_reset();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_pulses", 32'(instr_valid | pc_advance), 32'd0);
        chk("rst_jump", 32'(Jump), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        fetch(32'h00000000, 0, 32'h08000010, 1'b0, a, adv);
        chk("t1_addr", a, 32'h0);
        chk("t1_adv", 32'(adv), 32'd1);
        chk("t1_jump", 32'(Jump), 32'd1);
        chk("t1_imm", imm, 32'h00000010);

        fetch(32'h00400004, 5, 32'h1000FFFC, 1'b0, a, adv);
        chk("t2_addr", a, 32'h00400004);
        chk("t2_imm", imm, 32'hFFFFFFFC);
        chk("t2_jump", 32'(Jump), 32'd0);

        fetch(32'h00000010, 2, 32'h0C000001, 1'b0, a, adv);
        chk("jal_jump", 32'(Jump), 32'd0);

        fetch(32'h00000020, TIMEOUT - 1, 32'h0800ABCD, 1'b0, a, adv);
        chk("late_ack_jump", 32'(Jump), 32'd1);
        chk("late_ack_imm", imm, 32'hFFFFABCD);

        repeat (3) @(negedge CLK);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge CLK);
        mem_ack = 1'b0;
        @(negedge CLK);
        chk("idle_stray_ack_instr", Instr, last_instr);
        chk("idle_stray_ack_pulse", 32'(instr_valid | pc_advance | mem_req), 32'd0);

        for (int n = 0; n < 20; n++) begin
            rd = $urandom;
            if ($urandom_range(0, 3) == 0) rd = {6'b000010, rd[25:0]};
            else if ($urandom_range(0, 3) == 0) rd = {6'b000011, rd[25:0]};
            fetch($urandom & 32'hFFFFFFFC, int'($urandom_range(0, TIMEOUT - 1)), rd, 1'b0, a, adv);
        end

        do_reset();
        pc_m = 32'h0;
        adv_total = 0;
        for (int n = 0; n < 3; n++) begin
            fetch(pc_m, int'($urandom_range(0, 3)), $urandom, 1'b1, a, adv);
            addrs.push_back(a);
            adv_total += adv;
            if (adv != 0) pc_m = pc_m + 32'd4;
        end
        fetch_en = 1'b0;
        chk("b2b_count", 32'(addrs.size()), 32'd3);
        chk("b2b_addr0", addrs[0], 32'h0);
        chk("b2b_addr1", addrs[1], 32'h4);
        chk("b2b_addr2", addrs[2], 32'h8);
        chk("b2b_pulses", 32'(adv_total), 32'd3);

        fetch(32'h00000040, 1, 32'h1234FFFF, 1'b0, a, adv);
        PC = 32'h00000080;
        fetch_en = 1'b1;
        @(negedge CLK);
        fetch_en = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("to_req_high", 32'(mem_req), 32'd1);
            @(negedge CLK);
        end
        chk("to_req_low", 32'(mem_req), 32'd0);
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_instr", Instr, 32'h1234FFFF);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        fetch_en = 1'b1;
        PC = 32'h0;
        @(negedge CLK);
        mem_ack = 1'b0;
        @(negedge CLK);
        chk("to_stray_instr", Instr, 32'h1234FFFF);
        chk("to_stray_pulse", 32'(instr_valid | pc_advance | mem_req), 32'd0);
        chk("to_stray_err", 32'(fetch_err), 32'd1);
        fetch_en = 1'b0;

        do_reset();
        PC = 32'h00000006;
        fetch_en = 1'b1;
        @(negedge CLK);
        chk("mis_err", 32'(fetch_err), 32'd1);
        chk("mis_req", 32'(mem_req), 32'd0);
        PC = 32'h00000008;
        for (int k = 0; k < 5; k++) begin
            mem_ack = k[0];
            @(negedge CLK);
            chk("mis_stuck_req", 32'(mem_req), 32'd0);
            chk("mis_stuck_err", 32'(fetch_err), 32'd1);
        end
        mem_ack = 1'b0;
        fetch_en = 1'b0;

        do_reset();
        fetch(32'h00000100, 0, 32'h0800FFFF, 1'b0, a, adv);
        PC = 32'h00000200;
        fetch_en = 1'b1;
        @(negedge CLK);
        fetch_en = 1'b0;
        chk("rr_req_before", 32'(mem_req), 32'd1);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge CLK);
        mem_ack = 1'b0;
        reset = 1'b1;
        last_instr = '0;
        chk("rr_req", 32'(mem_req), 32'd0);
        chk("rr_instr", Instr, 32'd0);
        chk("rr_err", 32'(fetch_err), 32'd0);
        chk("rr_pulse", 32'(instr_valid | pc_advance), 32'd0);
        fetch(32'h00000300, 3, 32'h08001234, 1'b0, a, adv);
        chk("rr_refetch_addr", a, 32'h00000300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
